// File: rtl/dual_port_be.sv
// rtl/dual_port_be.sv - byte-enable dual-port RAM with read pipeline and clear engine
module dual_port_be #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 512,
  parameter int              ADD_WIDTH = 9,
  parameter int              RD_LAT    = 1,
  parameter int              COLLISION = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADD_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic                 rd_en,
  input  logic [ADD_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rd_valid,
  input  logic                 clr,
  output logic                 busy,
  output logic                 err
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADD_WIDTH:0]   DEPTH_W   = (ADD_WIDTH + 1)'(DEPTH);
  localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [ADD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;
  logic                   pipe_valid_q, pipe_valid_d;
  logic [WIDTH-1:0]       pipe_data_q, pipe_data_d;

  logic                   wr_ok, rd_ok, clear_we;
  logic [WIDTH-1:0]       rd_word;

  assign busy     = (state_q == CLEAR);
  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

  // clr in IDLE takes priority over a same-cycle write
  assign wr_ok    = wr_en && !busy && !clr && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok    = rd_en && !busy && ({1'b0, rd_addr} < DEPTH_W);
  assign clear_we = busy && !rst;

  always_comb begin
    rd_word = mem[rd_addr];
    if (COLLISION != 0 && wr_ok && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = (wr_en && !wr_ok) || (rd_en && !rd_ok);
    pipe_valid_d = rd_ok;
    pipe_data_d  = rd_ok ? rd_word : pipe_data_q;
    rd_valid_d   = 1'b0;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // the second stage keeps a sampled word immune to later writes
    if (RD_LAT == 1) begin
      rd_valid_d = rd_ok;
      if (rd_ok) rdata_d = rd_word;
    end else begin
      rd_valid_d = pipe_valid_q;
      if (pipe_valid_q) rdata_d = pipe_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      rdata_q      <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      rd_valid_q   <= rd_valid_d;
      err_q        <= err_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_be.sv
// tb/tb_dual_port_be.sv - directed bench for dual_port_be (RD_LAT=1/read-first and RD_LAT=2/write-first)
module tb_dual_port_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        clr = 1'b0;

  logic [31:0] rdata_a, rdata_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dual_port_be #(.WIDTH(32), .DEPTH(12), .ADD_WIDTH(4), .RD_LAT(1), .COLLISION(0), .INIT_VAL(32'h0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata_a), .rd_valid(rd_valid_a),
    .clr(clr), .busy(busy_a), .err(err_a));

  dual_port_be #(.WIDTH(32), .DEPTH(12), .ADD_WIDTH(4), .RD_LAT(2), .COLLISION(1), .INIT_VAL(32'h0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata_b), .rd_valid(rd_valid_b),
    .clr(clr), .busy(busy_b), .err(err_b));

  function automatic logic [31:0] pat(input int i);
    pat = {8'(i + 1), 8'hA5, 8'(3 * i), 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wdata = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic test_reset();
    int n;
    tick(); tick();
    checks++; if (rdata_a !== 32'h0 || rd_valid_a !== 1'b0 || err_a !== 1'b0)
      begin errors++; $display("FAIL reset_outputs_a: rdata=%h rd_valid=%b err=%b, required 0/0/0", rdata_a, rd_valid_a, err_a); end
    checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1)
      begin errors++; $display("FAIL reset_busy: busy_a=%b busy_b=%b, required 1", busy_a, busy_b); end
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); n++;
      if (!busy_a) break;
    end
    checks++; if (n !== 12)
      begin errors++; $display("FAIL reset_clear_len: busy edges=%0d, required 12", n); end
    checks++; if (busy_b !== 1'b0)
      begin errors++; $display("FAIL reset_clear_len_b: busy_b=%b, required 0", busy_b); end
    n = 0;
    for (int i = 0; i < 12; i++) if (dut_a.mem[i] !== 32'h0 || dut_b.mem[i] !== 32'h0) n++;
    checks++; if (n !== 0)
      begin errors++; $display("FAIL reset_mem_zero: nonzero words=%0d, required 0", n); end
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    checks++; if (dut_a.mem[3] !== 32'hAA22CC44)
      begin errors++; $display("FAIL be_mem: mem[3]=%h, required aa22cc44", dut_a.mem[3]); end
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_valid_a !== 1'b1 || rdata_a !== 32'hAA22CC44)
      begin errors++; $display("FAIL be_read_lat1: rd_valid=%b rdata=%h, required 1/aa22cc44", rd_valid_a, rdata_a); end
    checks++; if (rd_valid_b !== 1'b0)
      begin errors++; $display("FAIL be_lat2_early: rd_valid_b=%b, required 0", rd_valid_b); end
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rdata_b !== 32'hAA22CC44)
      begin errors++; $display("FAIL be_read_lat2: rd_valid=%b rdata=%h, required 1/aa22cc44", rd_valid_b, rdata_b); end
    checks++; if (rd_valid_a !== 1'b0 || rdata_a !== 32'hAA22CC44)
      begin errors++; $display("FAIL be_hold_lat1: rd_valid=%b rdata=%h, required 0/aa22cc44", rd_valid_a, rdata_a); end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 4'd5; wdata = 32'hFFFFFFFF; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    checks++; if (rd_valid_a !== 1'b1 || rdata_a !== 32'h0)
      begin errors++; $display("FAIL coll_read_first: rd_valid=%b rdata=%h, required 1/00000000", rd_valid_a, rdata_a); end
    tick();
    checks++; if (rd_valid_b !== 1'b1 || rdata_b !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL coll_write_first: rd_valid=%b rdata=%h, required 1/ffffffff", rd_valid_b, rdata_b); end
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wdata = 32'h12345678; wr_be = 4'b1111;
    tick();
    wr_en = 1'b0; wr_be = '0;
    checks++; if (rd_valid_b !== 1'b1 || rdata_b !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL lat2_late_write: rd_valid=%b rdata=%h, required 1/ffffffff", rd_valid_b, rdata_b); end
    checks++; if (dut_b.mem[5] !== 32'h12345678)
      begin errors++; $display("FAIL lat2_late_write_mem: mem[5]=%h, required 12345678", dut_b.mem[5]); end
  endtask

  task automatic test_errors();
    int n;
    do_write(4'd13, 32'hDEADBEEF, 4'b1111);
    checks++; if (err_a !== 1'b1 || err_b !== 1'b1)
      begin errors++; $display("FAIL err_wr_range: err_a=%b err_b=%b, required 1", err_a, err_b); end
    checks++; if (dut_a.mem[3] !== 32'hAA22CC44)
      begin errors++; $display("FAIL err_wr_range_mem: mem[3]=%h, required aa22cc44", dut_a.mem[3]); end
    tick();
    checks++; if (err_a !== 1'b0)
      begin errors++; $display("FAIL err_one_cycle: err=%b, required 0", err_a); end
    rd_en = 1'b1; rd_addr = 4'd13;
    tick();
    rd_en = 1'b0;
    checks++; if (err_a !== 1'b1 || rd_valid_a !== 1'b0 || rdata_a !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL err_rd_range: err=%b rd_valid=%b rdata=%h, required 1/0/ffffffff", err_a, rd_valid_a, rdata_a); end
    tick();
    checks++; if (rd_valid_b !== 1'b0 || rdata_b !== 32'hFFFFFFFF || err_b !== 1'b0)
      begin errors++; $display("FAIL err_rd_range_b: rd_valid=%b rdata=%h err=%b, required 0/ffffffff/0", rd_valid_b, rdata_b, err_b); end
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wdata = 32'h55555555; wr_be = 4'b1111;
    tick();
    clr = 1'b0; wr_en = 1'b0; wr_be = '0;
    checks++; if (err_a !== 1'b1 || busy_a !== 1'b1)
      begin errors++; $display("FAIL err_wr_with_clr: err=%b busy=%b, required 1/1", err_a, busy_a); end
    tick(); tick();
    wr_en = 1'b1; wr_addr = 4'd0; wdata = 32'h77777777; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    checks++; if (err_a !== 1'b1 || rd_valid_a !== 1'b0)
      begin errors++; $display("FAIL err_busy: err=%b rd_valid=%b, required 1/0", err_a, rd_valid_a); end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); n++;
      if (!busy_a) break;
    end
    checks++; if (n !== 7)
      begin errors++; $display("FAIL clr_no_extend: remaining busy edges=%0d, required 7", n); end
    checks++; if (dut_a.mem[0] !== 32'h0 || dut_a.mem[2] !== 32'h0 || dut_a.mem[3] !== 32'h0)
      begin errors++; $display("FAIL err_busy_mem: mem[0]=%h mem[2]=%h mem[3]=%h, required 0", dut_a.mem[0], dut_a.mem[2], dut_a.mem[3]); end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 12; i++) do_write(4'(i), pat(i), 4'b1111);
    bad = 0;
    for (int i = 0; i < 12; i++) if (dut_a.mem[i] !== pat(i)) bad++;
    checks++; if (bad !== 0)
      begin errors++; $display("FAIL b2b_fill: bad words=%0d, required 0", bad); end
    for (int k = 0; k <= 12; k++) begin
      rd_en = (k < 12); rd_addr = 4'(k);
      tick();
      if (k < 12) begin
        checks++; if (rd_valid_a !== 1'b1 || rdata_a !== pat(k))
          begin errors++; $display("FAIL b2b_lat1[%0d]: rd_valid=%b rdata=%h, required 1/%h", k, rd_valid_a, rdata_a, pat(k)); end
      end else begin
        checks++; if (rd_valid_a !== 1'b0)
          begin errors++; $display("FAIL b2b_lat1_end: rd_valid=%b, required 0", rd_valid_a); end
      end
      if (k >= 1) begin
        checks++; if (rd_valid_b !== 1'b1 || rdata_b !== pat(k - 1))
          begin errors++; $display("FAIL b2b_lat2[%0d]: rd_valid=%b rdata=%h, required 1/%h", k - 1, rd_valid_b, rdata_b, pat(k - 1)); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    checks++; if (dut_a.mem[5] !== 32'h0 || dut_a.mem[6] !== pat(6))
      begin errors++; $display("FAIL mid_clear_pos: mem[5]=%h mem[6]=%h, required 0/%h", dut_a.mem[5], dut_a.mem[6], pat(6)); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || busy_a !== 1'b1 || rd_valid_b !== 1'b0)
      begin errors++; $display("FAIL async_reset: rdata_a=%h rdata_b=%h busy=%b rd_valid_b=%b, required 0/0/1/0", rdata_a, rdata_b, busy_a, rd_valid_b); end
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); n++;
      if (!busy_a) break;
    end
    checks++; if (n !== 12)
      begin errors++; $display("FAIL restart_len: busy edges=%0d, required 12", n); end
    n = 0;
    for (int i = 0; i < 12; i++) if (dut_a.mem[i] !== 32'h0) n++;
    checks++; if (n !== 0)
      begin errors++; $display("FAIL restart_mem_zero: nonzero words=%0d, required 0", n); end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_errors();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
